// File: rtl/counter_pkg.sv
// Shared constants, per-edge action enum and load clamp helper for param_moore_counter.
package counter_pkg;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  localparam int MODE_LEVEL = 0;
  localparam int MODE_EDGE  = 1;

  typedef enum logic [1:0] {
    ACT_HOLD,
    ACT_STEP,
    ACT_LOAD
  } action_e;

  function automatic logic [31:0] clamp_to_max(input logic [31:0] value, input logic [31:0] max);
    return (value > max) ? max : value;
  endfunction

endpackage

// File: rtl/param_moore_counter_if.sv
// Control/status bundle for param_moore_counter; the counter takes the slave side.
// ovf_o exists only when MOORE_COUNTER_OVF_STICKY_EN is defined.
interface param_moore_counter_if #(
  parameter int WIDTH = 4
);

  logic             in_i;
  logic             down_i;
  logic             load_i;
  logic [WIDTH-1:0] load_val_i;
  logic [WIDTH-1:0] count_o;
  logic             tc_o;
  logic             busy_edge_o;
`ifdef MOORE_COUNTER_OVF_STICKY_EN
  logic             ovf_o;

  modport master (
    output in_i, down_i, load_i, load_val_i,
    input  count_o, tc_o, busy_edge_o, ovf_o
  );

  modport slave (
    input  in_i, down_i, load_i, load_val_i,
    output count_o, tc_o, busy_edge_o, ovf_o
  );
`else
  modport master (
    output in_i, down_i, load_i, load_val_i,
    input  count_o, tc_o, busy_edge_o
  );

  modport slave (
    input  in_i, down_i, load_i, load_val_i,
    output count_o, tc_o, busy_edge_o
  );
`endif

endinterface

// File: rtl/edge_detect_rise.sv
// Rising-edge qualifier: one flop holding the previous sample plus an AND-NOT.
module edge_detect_rise (
  input  logic clk_i,
  input  logic reset_i,
  input  logic sig_i,
  output logic prev_o,
  output logic rise_o
);

  always_ff @(posedge clk_i) begin
    if (reset_i) prev_o <= 1'b0;
    else         prev_o <= sig_i;
  end

  assign rise_o = sig_i & ~prev_o;

endmodule

// File: rtl/param_moore_counter.sv
// N-bit Moore up/down counter with load, wrap/saturate boundaries and optional edge-qualified stepping.
// Optional sticky overflow flag ovf_o is enabled by defining MOORE_COUNTER_OVF_STICKY_EN.
module param_moore_counter
  import counter_pkg::*;
#(
  parameter int          WIDTH     = 4,
  parameter int unsigned MAX_COUNT = (2**WIDTH) - 1,
  parameter int          EDGE_MODE = MODE_LEVEL,
  parameter bit          SATURATE  = 1'b0
) (
  input logic                  clk_i,
  input logic                  reset_i,
  param_moore_counter_if.slave bus
);

  localparam logic [WIDTH:0]   MAX_EXT = (WIDTH+1)'(MAX_COUNT);
  localparam logic [WIDTH:0]   ONE_EXT = (WIDTH+1)'(1);
  localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MAX_COUNT);

  logic [WIDTH-1:0] count_q, count_d, step_val;
  logic [WIDTH:0]   count_ext, up_ext, down_ext;
  logic             dir_q;
  logic             prev_in;
  logic             step_req;
  logic             blocked;
  action_e          action;

  generate
    if (EDGE_MODE == MODE_EDGE) begin : g_edge
      edge_detect_rise u_edge (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .sig_i  (bus.in_i),
        .prev_o (prev_in),
        .rise_o (step_req)
      );
    end else begin : g_level
      always_ff @(posedge clk_i) begin
        if (reset_i) prev_in <= 1'b0;
        else         prev_in <= bus.in_i;
      end
      assign step_req = bus.in_i;
    end
  endgenerate

  // Boundary test is done on the widened value so +1 at the top of the range cannot alias to 0.
  always_comb begin
    count_ext = {1'b0, count_q};
    up_ext    = count_ext + ONE_EXT;
    down_ext  = count_ext - ONE_EXT;
    blocked   = 1'b0;
    step_val  = count_q;
    if (bus.down_i == DIR_DOWN) begin
      blocked  = (count_q == '0);
      step_val = blocked ? (SATURATE ? count_q : MAX_CNT) : down_ext[WIDTH-1:0];
    end else begin
      blocked  = (count_ext >= MAX_EXT);
      step_val = blocked ? (SATURATE ? count_q : '0) : up_ext[WIDTH-1:0];
    end

    action = ACT_HOLD;
    if (bus.load_i)     action = ACT_LOAD;
    else if (step_req)  action = ACT_STEP;

    count_d = count_q;
    case (action)
      ACT_LOAD: count_d = WIDTH'(clamp_to_max(32'(bus.load_val_i), 32'(MAX_COUNT)));
      ACT_STEP: count_d = step_val;
      default:  count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q <= '0;
      dir_q   <= DIR_UP;
    end else begin
      count_q <= count_d;
      dir_q   <= bus.down_i;
    end
  end

`ifdef MOORE_COUNTER_OVF_STICKY_EN
  logic ovf_q;

  always_ff @(posedge clk_i) begin
    if (reset_i)                              ovf_q <= 1'b0;
    else if (action == ACT_LOAD)              ovf_q <= 1'b0;
    else if (action == ACT_STEP && blocked)   ovf_q <= 1'b1;
  end

  assign bus.ovf_o = ovf_q;
`endif

  // Terminal count uses the registered direction so no input reaches an output combinationally.
  assign bus.tc_o        = (dir_q == DIR_UP) ? ({1'b0, count_q} == MAX_EXT) : (count_q == '0);
  assign bus.count_o     = count_q;
  assign bus.busy_edge_o = prev_in;

endmodule

// File: tb/tb_param_moore_counter.sv
// Scoreboard bench for param_moore_counter: three configurations driven with directed vectors.
module tb_param_moore_counter;

  typedef struct {
    int    sel;
    int    exp_count;
    logic  exp_tc;
    logic  exp_busy;
    logic  exp_ovf;
    string name;
  } sb_item_t;

  sb_item_t sb_queue[$];
  int       checks = 0;
  int       errors = 0;

  logic clk = 1'b0;
  logic rst_a, rst_b, rst_c;

  always #5 clk = ~clk;

  param_moore_counter_if #(.WIDTH(2)) if_a ();
  param_moore_counter_if #(.WIDTH(4)) if_b ();
  param_moore_counter_if #(.WIDTH(4)) if_c ();

  param_moore_counter #(.WIDTH(2)) dut_a (
    .clk_i(clk), .reset_i(rst_a), .bus(if_a)
  );

  param_moore_counter #(.WIDTH(4), .MAX_COUNT(9), .EDGE_MODE(0), .SATURATE(1'b1)) dut_b (
    .clk_i(clk), .reset_i(rst_b), .bus(if_b)
  );

  param_moore_counter #(.WIDTH(4), .MAX_COUNT(9), .EDGE_MODE(1), .SATURATE(1'b0)) dut_c (
    .clk_i(clk), .reset_i(rst_c), .bus(if_c)
  );

  task automatic compareField(input string name, input string field, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("[TB] FAIL %s.%s got %0d expected %0d", name, field, got, exp);
    end
  endtask

  task automatic checkOutput(input sb_item_t item);
    int   got_count;
    logic got_tc, got_busy, got_ovf;
    got_ovf = 1'b0;
    case (item.sel)
      0: begin
        got_count = int'(if_a.count_o); got_tc = if_a.tc_o; got_busy = if_a.busy_edge_o;
`ifdef MOORE_COUNTER_OVF_STICKY_EN
        got_ovf = if_a.ovf_o;
`endif
      end
      1: begin
        got_count = int'(if_b.count_o); got_tc = if_b.tc_o; got_busy = if_b.busy_edge_o;
`ifdef MOORE_COUNTER_OVF_STICKY_EN
        got_ovf = if_b.ovf_o;
`endif
      end
      default: begin
        got_count = int'(if_c.count_o); got_tc = if_c.tc_o; got_busy = if_c.busy_edge_o;
`ifdef MOORE_COUNTER_OVF_STICKY_EN
        got_ovf = if_c.ovf_o;
`endif
      end
    endcase
    compareField(item.name, "count", got_count, item.exp_count);
    compareField(item.name, "tc", int'(got_tc), int'(item.exp_tc));
    if (item.sel == 2) compareField(item.name, "busy_edge", int'(got_busy), int'(item.exp_busy));
`ifdef MOORE_COUNTER_OVF_STICKY_EN
    compareField(item.name, "ovf", int'(got_ovf), int'(item.exp_ovf));
`else
    if (got_ovf !== 1'b0) compareField(item.name, "ovf_absent", int'(got_ovf), 0);
`endif
  endtask

  // Monitor: registered outputs settle just after each rising edge.
  always @(posedge clk) begin
    #1;
    if (sb_queue.size() > 0) checkOutput(sb_queue.pop_front());
  end

  task automatic applyStimulus(input int sel, input logic rst, input logic in, input logic dn,
                               input logic ld, input int lval, input int exp_count,
                               input logic exp_tc, input logic exp_busy, input logic exp_ovf,
                               input string name);
    sb_item_t item;
    @(negedge clk);
    rst_a = 1'b0; if_a.in_i = 1'b0; if_a.load_i = 1'b0;
    rst_b = 1'b0; if_b.in_i = 1'b0; if_b.load_i = 1'b0;
    rst_c = 1'b0; if_c.in_i = 1'b0; if_c.load_i = 1'b0;
    case (sel)
      0: begin rst_a = rst; if_a.in_i = in; if_a.down_i = dn; if_a.load_i = ld; if_a.load_val_i = 2'(lval); end
      1: begin rst_b = rst; if_b.in_i = in; if_b.down_i = dn; if_b.load_i = ld; if_b.load_val_i = 4'(lval); end
      default: begin rst_c = rst; if_c.in_i = in; if_c.down_i = dn; if_c.load_i = ld; if_c.load_val_i = 4'(lval); end
    endcase
    item = '{sel: sel, exp_count: exp_count, exp_tc: exp_tc, exp_busy: exp_busy, exp_ovf: exp_ovf, name: name};
    sb_queue.push_back(item);
    @(posedge clk);
  endtask

  initial begin
    #100000;
    $display("[TB] watchdog expired");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int       cnt;
    sb_item_t pend;

    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    if_a.in_i = 1'b0; if_a.down_i = 1'b0; if_a.load_i = 1'b0; if_a.load_val_i = '0;
    if_b.in_i = 1'b0; if_b.down_i = 1'b0; if_b.load_i = 1'b0; if_b.load_val_i = '0;
    if_c.in_i = 1'b0; if_c.down_i = 1'b0; if_c.load_i = 1'b0; if_c.load_val_i = '0;
    repeat (2) @(posedge clk);

    // WIDTH=2 wrap: 1,2,3,0,1,2 with tc only at 3
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, "A_reset");
    applyStimulus(0, 0, 1, 0, 0, 0, 1, 0, 0, 0, "A_step1");
    applyStimulus(0, 0, 1, 0, 0, 0, 2, 0, 0, 0, "A_step2");
    applyStimulus(0, 0, 1, 0, 0, 0, 3, 1, 0, 0, "A_step3");
    applyStimulus(0, 0, 1, 0, 0, 0, 0, 0, 0, 1, "A_wrap");
    applyStimulus(0, 0, 1, 0, 0, 0, 1, 0, 0, 1, "A_step5");
    applyStimulus(0, 0, 1, 0, 0, 0, 2, 0, 0, 1, "A_step6");
    applyStimulus(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, "A_reset_with_in");

    // MAX_COUNT=9 saturating: up 12 then down 11
    applyStimulus(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, "B_reset");
    for (int i = 1; i <= 12; i++) begin
      cnt = (i < 9) ? i : 9;
      applyStimulus(1, 0, 1, 0, 0, 0, cnt, logic'(cnt == 9), 0, logic'(i >= 10), "B_up_sat");
    end
    for (int i = 1; i <= 11; i++) begin
      cnt = (i < 9) ? 9 - i : 0;
      applyStimulus(1, 0, 1, 1, 0, 0, cnt, logic'(cnt == 0), 0, 1, "B_down_sat");
    end
    applyStimulus(1, 0, 0, 0, 1, 7,  7, 0, 0, 0, "B_load7");
    applyStimulus(1, 0, 1, 0, 1, 3,  3, 0, 0, 0, "B_load_beats_step");
    applyStimulus(1, 0, 0, 0, 1, 15, 9, 1, 0, 0, "B_load_clamp");
    applyStimulus(1, 0, 1, 0, 0, 0,  9, 1, 0, 1, "B_sat_hold");

    // Edge mode: level high out of reset yields one step, then four toggles
    applyStimulus(2, 1, 1, 0, 0, 0, 0, 0, 0, 0, "C_reset_in_high");
    for (int i = 0; i < 10; i++) applyStimulus(2, 0, 1, 0, 0, 0, 1, 0, 1, 0, "C_held_high");
    for (int k = 1; k <= 4; k++) begin
      applyStimulus(2, 0, 0, 0, 0, 0, k,     0, 0, 0, "C_toggle_low");
      applyStimulus(2, 0, 1, 0, 0, 0, k + 1, 0, 1, 0, "C_toggle_high");
    end
    applyStimulus(2, 0, 0, 0, 0, 0, 5, 0, 0, 0, "C_low");
    applyStimulus(2, 0, 1, 0, 0, 0, 6, 0, 1, 0, "C_six");

    // Reset raised between edges must not disturb the count until the next edge
    @(negedge clk);
    rst_c = 1'b1; if_c.in_i = 1'b0;
    sb_queue.push_back('{sel: 2, exp_count: 0, exp_tc: 0, exp_busy: 0, exp_ovf: 0, name: "C_reset_edge"});
    #1;
    pend = '{sel: 2, exp_count: 6, exp_tc: 0, exp_busy: 1, exp_ovf: 0, name: "C_reset_pending"};
    checkOutput(pend);
    @(posedge clk);

    applyStimulus(2, 1, 0, 0, 1, 7, 0, 0, 0, 0, "C_reset_and_load");
    applyStimulus(2, 0, 0, 1, 0, 0, 0, 1, 0, 0, "C_dir_tc");
    applyStimulus(2, 0, 1, 1, 0, 0, 9, 0, 1, 1, "C_down_wrap");
    applyStimulus(2, 0, 0, 0, 0, 0, 9, 1, 0, 1, "C_tc_up");
    applyStimulus(2, 0, 1, 0, 0, 0, 0, 0, 1, 1, "C_up_wrap");
    applyStimulus(2, 0, 0, 0, 1, 4, 4, 0, 0, 0, "C_load4");
    applyStimulus(2, 0, 1, 0, 1, 2, 2, 0, 1, 0, "C_load_edge_prev");
    applyStimulus(2, 0, 1, 0, 0, 0, 2, 0, 1, 0, "C_no_step_after_load");

    @(negedge clk);
    for (int i = 0; i < 5 && sb_queue.size() > 0; i++) @(negedge clk);
    compareField("drain", "queue_left", sb_queue.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
